// File: rtl/video_src_switch_pkg.sv
// Shared types and constants for the frame-safe camera source switch.
// Imported by the switch top and its output register slice.
package video_switch_pkg;

   localparam int DATA_W = 24;

   localparam logic SRC_OS = 1'b0;
   localparam logic SRC_YS = 1'b1;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      DRAIN = 2'd1,
      SYNC  = 2'd2
   } sw_state_t;

   // A start-of-frame beat is one whose tuser flag is presented with tvalid.
   function automatic logic is_sof(input logic tvalid, input logic tuser);
      return tvalid & tuser;
   endfunction

endpackage

// File: rtl/video_src_switch_reg_slice.sv
// One-deep AXI4-Stream register slice carrying tdata/tlast/tuser.
// The upstream ready is high whenever the slot is empty or is emptying this cycle.
module axis_reg_slice #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   input  logic              s_tuser,
   output logic              s_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   output logic              m_tuser,
   input  logic              m_tready
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              user_q, user_d;

   assign s_tready = ~valid_q | m_tready;
   assign m_tdata  = data_q;
   assign m_tvalid = valid_q;
   assign m_tlast  = last_q;
   assign m_tuser  = user_q;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      user_d  = user_q;
      if (s_tvalid & s_tready) begin
         data_d  = s_tdata;
         valid_d = 1'b1;
         last_d  = s_tlast;
         user_d  = s_tuser;
      end else if (m_tready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= {DATA_W{1'b0}};
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         user_q  <= user_d;
      end
   end

endmodule

// File: rtl/video_src_switch.sv
// Frame-safe two-camera source switch: drains the active source to a frame end,
// flushes the new source until its SOF, then forwards whole frames only.
module video_src_switch
   import video_switch_pkg::*;
#(
   parameter int               DATA_W  = video_switch_pkg::DATA_W,
   parameter int               TMO_W   = 24,
   parameter logic [TMO_W-1:0] TMO_CYC = 24'd2_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_req,
   output logic              sel_cur,
   output logic              busy,
   output logic              sw_tmo,
   input  logic [DATA_W-1:0] os_tdata,
   input  logic              os_tvalid,
   input  logic              os_tlast,
   input  logic              os_tuser,
   output logic              os_tready,
   input  logic [DATA_W-1:0] ys_tdata,
   input  logic              ys_tvalid,
   input  logic              ys_tlast,
   input  logic              ys_tuser,
   output logic              ys_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   output logic              m_tuser,
   input  logic              m_tready
);

   localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_ONE;

   sw_state_t         state_q, state_d;
   logic              sel_cur_q, sel_cur_d;
   logic              tgt_q, tgt_d;
   logic [TMO_W-1:0]  cnt_q, cnt_d;
   logic              sw_tmo_q, sw_tmo_d;
   logic              busy_q;

   logic [DATA_W-1:0] act_tdata_s;
   logic              act_tvalid_s, act_tlast_s, act_tuser_s;
   logic              act_sof_s, oth_sof_s;
   logic              act_rdy_s, oth_rdy_s;
   logic              slice_vld_s, slice_rdy_s;

   always_comb begin
      if (sel_cur_q == SRC_YS) begin
         act_tdata_s  = ys_tdata;
         act_tvalid_s = ys_tvalid;
         act_tlast_s  = ys_tlast;
         act_tuser_s  = ys_tuser;
         oth_sof_s    = is_sof(os_tvalid, os_tuser);
      end else begin
         act_tdata_s  = os_tdata;
         act_tvalid_s = os_tvalid;
         act_tlast_s  = os_tlast;
         act_tuser_s  = os_tuser;
         oth_sof_s    = is_sof(ys_tvalid, ys_tuser);
      end
      act_sof_s = is_sof(act_tvalid_s, act_tuser_s);
   end

   // In SYNC the switch target is always the non-active source, so "other" is the new camera.
   always_comb begin
      state_d     = state_q;
      sel_cur_d   = sel_cur_q;
      tgt_d       = tgt_q;
      cnt_d       = cnt_q;
      sw_tmo_d    = sw_tmo_q;
      act_rdy_s   = 1'b1;
      oth_rdy_s   = 1'b1;
      slice_vld_s = 1'b0;
      case (state_q)
         PASS: begin
            act_rdy_s   = slice_rdy_s;
            slice_vld_s = act_tvalid_s;
            if (sel_req != sel_cur_q) begin
               tgt_d   = sel_req;
               state_d = DRAIN;
            end else begin
               state_d = PASS;
            end
         end
         DRAIN: begin
            if (act_sof_s) begin
               act_rdy_s = 1'b0;
               cnt_d     = {TMO_W{1'b0}};
               state_d   = SYNC;
            end else begin
               act_rdy_s   = slice_rdy_s;
               slice_vld_s = act_tvalid_s;
            end
         end
         SYNC: begin
            if (oth_sof_s) begin
               oth_rdy_s = 1'b0;
               sel_cur_d = tgt_q;
               sw_tmo_d  = 1'b0;
               cnt_d     = {TMO_W{1'b0}};
               state_d   = PASS;
            end else if (cnt_q == TMO_LAST) begin
               sw_tmo_d = 1'b1;
               cnt_d    = {TMO_W{1'b0}};
               state_d  = PASS;
            end else begin
               cnt_d = cnt_q + TMO_ONE;
            end
         end
         default: begin
            state_d = PASS;
         end
      endcase

      if (sel_cur_q == SRC_YS) begin
         ys_tready = act_rdy_s;
         os_tready = oth_rdy_s;
      end else begin
         os_tready = act_rdy_s;
         ys_tready = oth_rdy_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PASS;
         sel_cur_q <= SRC_OS;
         tgt_q     <= SRC_OS;
         cnt_q     <= {TMO_W{1'b0}};
         sw_tmo_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_cur_q <= sel_cur_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         sw_tmo_q  <= sw_tmo_d;
         busy_q    <= (state_d != PASS);
      end
   end

   assign sel_cur = sel_cur_q;
   assign busy    = busy_q;
   assign sw_tmo  = sw_tmo_q;

   axis_reg_slice #(
      .DATA_W (DATA_W)
   ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (act_tdata_s),
      .s_tvalid (slice_vld_s),
      .s_tlast  (act_tlast_s),
      .s_tuser  (act_tuser_s),
      .s_tready (slice_rdy_s),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tuser  (m_tuser),
      .m_tready (m_tready)
   );

endmodule

// File: tb/tb_video_src_switch.sv
// Directed bench for video_src_switch: a vector table for plain pass-through,
// then hand-written sequences for switching, backpressure, timeout and reset.
module tb_video_src_switch;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel_req;
   logic        sel_cur, busy, sw_tmo;
   logic [23:0] os_tdata, ys_tdata, m_tdata;
   logic        os_tvalid, os_tlast, os_tuser, os_tready;
   logic        ys_tvalid, ys_tlast, ys_tuser, ys_tready;
   logic        m_tvalid, m_tlast, m_tuser, m_tready;

   always #5 clk = ~clk;

   video_src_switch #(.DATA_W(24), .TMO_W(24), .TMO_CYC(24'd16)) dut (
      .clk(clk), .rst(rst), .sel_req(sel_req), .sel_cur(sel_cur), .busy(busy), .sw_tmo(sw_tmo),
      .os_tdata(os_tdata), .os_tvalid(os_tvalid), .os_tlast(os_tlast), .os_tuser(os_tuser), .os_tready(os_tready),
      .ys_tdata(ys_tdata), .ys_tvalid(ys_tvalid), .ys_tlast(ys_tlast), .ys_tuser(ys_tuser), .ys_tready(ys_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tready(m_tready)
   );

   typedef struct packed {
      logic        os_v;
      logic [23:0] os_d;
      logic        os_u, os_l;
      logic        ys_v, ys_u;
      logic        m_rdy;
      logic        x_os_rdy, x_ys_rdy, x_m_v;
      logic [23:0] x_m_d;
      logic        x_m_u, x_m_l;
   } vec_t;

   vec_t vecs [12];
   int   n_cmp = 0;
   int   n_err = 0;

   // Stream generators: frames of 8 beats, data = {tag, frame, beat}.
   logic       os_en, ys_en;
   logic [7:0] os_frm, os_beat, ys_frm, ys_beat;
   logic       os_hs, ys_hs;
   logic       os_rdy_pre, ys_rdy_pre, busy_pre;
   // Output monitor state.
   logic        chk_cont, fresh, prev_stall, last_src;
   logic [7:0]  last_beat;
   logic [25:0] prev_vec;
   int          sw_seen, os_out;
   logic        found;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic mon();
      logic       src;
      logic [7:0] beat;
      os_rdy_pre = os_tready;
      ys_rdy_pre = ys_tready;
      busy_pre   = busy;
      os_hs      = os_tvalid & os_tready;
      ys_hs      = ys_tvalid & ys_tready;
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, prev_vec});
      prev_stall = m_tvalid & ~m_tready;
      prev_vec   = {m_tdata, m_tuser, m_tlast};
      if (m_tvalid && m_tready && chk_cont) begin
         src  = (m_tdata[23:16] == 8'hB0);
         beat = m_tdata[7:0];
         chk("frame_flags", {m_tuser, m_tlast}, {beat == 8'd0, beat == 8'd7});
         if (fresh) begin
            fresh = 1'b0;
         end else if (src == last_src) begin
            chk("beat_order", beat, (last_beat + 8'd1) & 8'd7);
         end else begin
            chk("switch_boundary", {last_beat, beat}, {8'd7, 8'd0});
            sw_seen++;
         end
         last_src  = src;
         last_beat = beat;
         if (!src) os_out++;
      end
   endtask

   task automatic cycle();
      os_tvalid = os_en;
      os_tdata  = {8'hA0, os_frm, os_beat};
      os_tuser  = (os_beat == 8'd0);
      os_tlast  = (os_beat == 8'd7);
      ys_tvalid = ys_en;
      ys_tdata  = {8'hB0, ys_frm, ys_beat};
      ys_tuser  = (ys_beat == 8'd0);
      ys_tlast  = (ys_beat == 8'd7);
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      if (os_hs) begin
         if (os_beat == 8'd7) begin os_beat = 8'd0; os_frm++; end
         else os_beat++;
      end
      if (ys_hs) begin
         if (ys_beat == 8'd7) begin ys_beat = 8'd0; ys_frm++; end
         else ys_beat++;
      end
   endtask

   initial begin
      //            os_v  os_d        u     l     ys_v  ys_u  mrdy  xos   xys   xmv   xm_d        xu    xl
      vecs[0]  = '{1'b1, 24'hA00000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00000, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 24'hA00001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00001, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 24'hA00002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'hA00001, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 24'hA00002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00002, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 24'hA00003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00003, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 24'hA00004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 24'hA00100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00100, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 24'hA00101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00101, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 24'hA00102, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00102, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 24'hA00103, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00103, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hA00103, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};

      rst = 1'b1; sel_req = 1'b0; m_tready = 1'b0;
      os_tvalid = 1'b0; os_tdata = 24'h0; os_tlast = 1'b0; os_tuser = 1'b0;
      ys_tvalid = 1'b0; ys_tdata = 24'h0; ys_tlast = 1'b0; ys_tuser = 1'b0;
      os_en = 1'b0; ys_en = 1'b0; os_frm = 8'd0; os_beat = 8'd0; ys_frm = 8'd0; ys_beat = 8'd3;
      chk_cont = 1'b0; fresh = 1'b1; prev_stall = 1'b0; last_src = 1'b0; last_beat = 8'd0;
      prev_vec = 26'd0; sw_seen = 0; os_out = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {m_tvalid, m_tdata, m_tuser, m_tlast, busy, sel_cur, sw_tmo}, 31'd0);
      rst = 1'b0;

      // Steady pass-through with os selected, including stalls and idle cycles.
      for (int i = 0; i < 12; i++) begin
         os_tvalid = vecs[i].os_v; os_tdata = vecs[i].os_d;
         os_tuser  = vecs[i].os_u; os_tlast = vecs[i].os_l;
         ys_tvalid = vecs[i].ys_v; ys_tuser = vecs[i].ys_u;
         ys_tdata  = 24'hB0FFFF;   ys_tlast = 1'b0;
         m_tready  = vecs[i].m_rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), {os_tready, ys_tready}, {vecs[i].x_os_rdy, vecs[i].x_ys_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_m_tvalid", i), m_tvalid, vecs[i].x_m_v);
         if (vecs[i].x_m_v)
            chk($sformatf("vec%0d_m_beat", i), {m_tdata, m_tuser, m_tlast}, {vecs[i].x_m_d, vecs[i].x_m_u, vecs[i].x_m_l});
         chk($sformatf("vec%0d_ctrl", i), {busy, sel_cur, sw_tmo}, 3'b000);
      end

      // Frame-safe switch os -> ys, requested mid-frame.
      os_en = 1'b1; ys_en = 1'b1; m_tready = 1'b1; chk_cont = 1'b1; fresh = 1'b1;
      for (int k = 0; k < 40 && os_beat != 8'd4; k++) cycle();
      sel_req = 1'b1;
      cycle();
      for (int k = 0; k < 100 && sel_cur == 1'b0; k++) begin
         chk("switch_busy", busy, 1'b1);
         cycle();
      end
      chk("switch_done", {sel_cur, busy, sw_tmo}, 3'b100);
      repeat (30) cycle();
      chk("switch_seen", sw_seen, 1);
      chk("switch_src", last_src, 1'b1);

      // Switch ys -> os while the output ready toggles 1010.
      for (int k = 0; k < 40 && ys_beat != 8'd4; k++) cycle();
      sel_req = 1'b0;
      for (int k = 0; k < 300 && sel_cur == 1'b1; k++) begin
         m_tready = ~m_tready;
         cycle();
      end
      for (int k = 0; k < 40; k++) begin
         m_tready = ~m_tready;
         cycle();
      end
      chk("bp_sel_cur", sel_cur, 1'b0);
      chk("bp_seen", sw_seen, 2);
      chk("bp_src", last_src, 1'b0);

      // Timeout: ys silent, so SYNC gives up after 16 cycles.
      m_tready = 1'b1; ys_en = 1'b0; chk_cont = 1'b0; sw_seen = 0;
      sel_req = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle();
         if (busy_pre && !os_rdy_pre) found = 1'b1;
      end
      chk("tmo_drain_sof", found, 1'b1);
      for (int k = 1; k < 16; k++) begin
         cycle();
         chk($sformatf("tmo_sync%0d", k), {busy, sw_tmo}, 2'b10);
      end
      cycle();
      chk("tmo_abort", {sw_tmo, sel_cur, busy}, 3'b100);
      chk_cont = 1'b1; fresh = 1'b1;
      cycle();
      chk("tmo_redrain", {busy, sw_tmo}, 2'b11);

      // ys SOF arrives on the last counter cycle: the switch must win.
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle();
         if (busy_pre && !os_rdy_pre) found = 1'b1;
      end
      chk("sim_drain_sof", found, 1'b1);
      repeat (15) cycle();
      chk("sim_pre", {busy, sw_tmo, sel_cur}, 3'b110);
      ys_en = 1'b1; ys_beat = 8'd0; ys_frm++;
      cycle();
      chk("sim_sof_held", ys_rdy_pre, 1'b0);
      chk("sim_switch", {sel_cur, sw_tmo, busy}, 3'b100);
      repeat (20) cycle();
      chk("sim_seen", sw_seen, 1);

      // Reset while waiting in SYNC with a beat stalled in the slice.
      os_en = 1'b0; chk_cont = 1'b0; sel_req = 1'b0; m_tready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         m_tready = ~(busy && ys_beat == 8'd0);
         cycle();
         if (busy_pre && !ys_rdy_pre) found = 1'b1;
      end
      chk("rst_sync_entry", found, 1'b1);
      m_tready = 1'b0;
      repeat (3) cycle();
      chk("rst_pre", {m_tvalid, busy, sel_cur}, 3'b111);
      rst = 1'b1;
      #1;
      chk("rst_async", {m_tvalid, busy, sel_cur, sw_tmo}, 4'b0000);
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      os_en = 1'b1; m_tready = 1'b1; chk_cont = 1'b1; fresh = 1'b1; os_out = 0;
      repeat (30) cycle();
      chk("rst_os_pass", os_out > 20, 1'b1);
      chk("rst_os_src", {last_src, sel_cur, busy}, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/video_src_switch.md
# video_src_switch

Frame-safe controller and arbiter for selecting between the two camera video streams (source 0 "os", source 1 "ys") feeding the display/encode pipeline. It supersedes a raw combinational select. Source changes are sequenced so that the output only ever carries whole frames, switching on a start-of-frame (tuser) boundary. The non-selected camera is flushed rather than stalled, so it stays free-running and frame-locked. Output is registered through a one-deep AXI4-Stream slice.

## Interface
- `DATA_W`, 24: pixel bus width (RGB888).
- `TMO_W`, 24: width of the SOF-wait timeout counter.
- `TMO_CYC`, 24'd2_000_000: cycles to wait for new-source SOF before aborting (about 20 ms at 100 MHz).
- `clk` in 1: single clock, all logic.
- `rst` in 1: asynchronous, active-high reset.
- `sel_req` in 1: requested source (0 = os, 1 = ys); level, synchronous to `clk`.
- `sel_cur` out 1: source currently driving the output.
- `busy` out 1: high while a switch is in progress (DRAIN or SYNC).
- `sw_tmo` out 1: sticky; set on timeout abort, cleared by the next successful switch or by `rst`.
- `os_tdata/tvalid/tlast/tuser` in DATA_W/1/1/1; `os_tready` out 1: source 0.
- `ys_tdata/tvalid/tlast/tuser` in DATA_W/1/1/1; `ys_tready` out 1: source 1.
- `m_tdata/tvalid/tlast/tuser` out DATA_W/1/1/1; `m_tready` in 1: output stream.

## Operation
- `tgt` is the latched target source. Active source = `sel_cur`. Other source = `!sel_cur`.
- `slice_rdy` = `!m_tvalid | m_tready`.
- State machine:
  - **PASS**
    - Active source: `tready = slice_rdy`; accepted beats enter the slice.
    - Other source: `tready = 1`; beats are discarded.
    - If `sel_req != sel_cur`: latch `tgt = sel_req`, go to DRAIN.
  - **DRAIN**
    - Active source keeps passing beats until it presents `tvalid & tuser`.
    - That SOF beat is not accepted (`tready = 0`). Go to SYNC.
    - Other source is still flushed.
    - The output therefore ends on a complete frame.
  - **SYNC**
    - Old source: `tready = 1`, flushed (including the held SOF beat).
    - New source (`tgt`): `tready = 1` while `!(tvalid & tuser)`, so data is discarded.
    - When new source presents `tvalid & tuser`: `tready = 0`, set `sel_cur = tgt`, clear `sw_tmo`, go to PASS. The held SOF beat is the first beat forwarded.
    - Timeout counter resets on SYNC entry and increments each SYNC cycle. At `TMO_CYC - 1`: set `sw_tmo`, leave `sel_cur` unchanged, go to PASS. Output resumes mid-frame from the old source.
- `sel_req` is sampled only in PASS; changes during DRAIN or SYNC are ignored until PASS is re-entered.
- If `sel_req` still differs from `sel_cur` after a timeout, a new switch starts on the next cycle.
- `busy = (state != PASS)`.

## Timing
- Reset (asynchronous, immediate):
  - state = PASS, `sel_cur = 0`, `tgt = 0`, counter = 0.
  - `m_tvalid = 0`, `m_tdata/tlast/tuser = 0`.
  - `busy = 0`, `sw_tmo = 0`.
  - The slice contents are dropped.
- Latency: an input beat accepted at edge N appears on `m_*` after edge N, i.e. 1 cycle.
- Slice holds `m_*` stable while `m_tvalid & !m_tready` (AXI-S rule). `m_tvalid` never drops without a handshake, except on reset.
- All `tready` outputs are combinational from state, `slice_rdy` and input `tvalid/tuser`. No combinational path from `sel_req` to any `tready` or `m_*`.
- PASS to DRAIN: 1 cycle after `sel_req` changes. DRAIN to SYNC: on the cycle the SOF is seen. SYNC to PASS: the same edge the new SOF is seen. The SOF beat is accepted no earlier than the following cycle.
- Timeout and SOF on the same cycle: SOF wins (switch succeeds).
- A beat already in the slice at switch time drains normally. No gaps are inserted beyond `slice_rdy` backpressure.

## Structure
- Package `video_switch_pkg` holds:
  - State enum `sw_state_t` {PASS, DRAIN, SYNC}.
  - Constants `SRC_OS = 1'b0`, `SRC_YS = 1'b1`.
  - `DATA_W` default.
- Sub-module `axis_reg_slice` (parameterised DATA_W, carries tdata/tlast/tuser) implements the 1-deep output register.
- The FSM, counter and ready steering live in the top module.

## Test plan
- **Steady pass:** `sel_req = 0`, os streams 4×2 frames with `m_tready = 1` -> `m_*` equals os beats delayed 1 cycle; `ys_tready` held 1.
- **Frame-safe switch:** raise `sel_req` to 1 mid-os-frame -> os frame completes on the output; next os SOF is not output; first ys beat output has `tuser = 1`; `sel_cur` 0→1; `busy` high throughout.
- **Backpressure:** `m_tready` toggles 1010 during a switch -> no beat lost or duplicated; `m_*` stable while stalled; beat count per frame = 8.
- **Timeout:** switch to ys with ys silent, `TMO_CYC = 16` -> after 16 SYNC cycles `sw_tmo = 1`, `sel_cur = 0`, FSM returns to PASS, DRAIN restarts next cycle.
- **Simultaneous SOF and timeout:** ys SOF on the final counter cycle -> switch succeeds, `sw_tmo = 0`.
- **Reset mid-SYNC:** assert `rst` -> `m_tvalid`, `busy` and `sel_cur` go to 0 immediately; after release, os frames pass.
